// File: rtl/imem_fetch_buf_if.sv
// Fetch/response handshake, flush and boot-loader write bundle for imem_fetch_buf.
// master = fetch unit / boot loader side, slave = the instruction memory.
interface imem_fetch_if #(
  parameter int PC_WIDTH  = 32,
  parameter int I_WIDTH   = 32,
  parameter int LANES     = 1,
  parameter int ADD_WIDTH = 13
);
  logic                       req_valid;
  logic                       req_ready;
  logic [PC_WIDTH-1:0]        pc;
  logic                       flush;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [PC_WIDTH-1:0]        rsp_pc;
  logic [I_WIDTH*LANES-1:0]   rsp_instr;
  logic [1:0]                 rsp_fault;
  logic                       load_en;
  logic                       load_busy;
  logic                       we;
  logic [ADD_WIDTH-1:0]       waddr;
  logic [I_WIDTH-1:0]         wdata;

  modport master (
    output req_valid, pc, flush, rsp_ready, load_en, we, waddr, wdata,
    input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault, load_busy
  );

  modport slave (
    input  req_valid, pc, flush, rsp_ready, load_en, we, waddr, wdata,
    output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault, load_busy
  );
endinterface

// File: rtl/imem_fetch_buf.sv
// Instruction memory with a valid/ready fetch port returning LANES consecutive
// words per request, a 2-entry response buffer for decode backpressure, and a
// RUN/DRAIN/LOAD state machine that hands exclusive write access to the loader.
// The synchronous read lands directly in the response buffer slot, so the
// buffer occupancy already accounts for the read that is in flight.
module imem_fetch_buf #(
  parameter int I_WIDTH   = 32,
  parameter int IMEM_SIZE = 2**15,
  parameter int LANES     = 1,
  parameter int PC_WIDTH  = 32,
  parameter int WORDS     = IMEM_SIZE >> 2,
  parameter int ADD_WIDTH = $clog2(IMEM_SIZE >> 2)
) (
  input logic         clk,
  input logic         rst,
  imem_fetch_if.slave bus
);

  localparam int ALIGN_W = $clog2(4 * LANES);
  localparam int RW      = I_WIDTH * LANES;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  // Fetch address must be aligned to the full LANES-word block.
  function automatic logic misaligned(input logic [PC_WIDTH-1:0] a);
    return a[ALIGN_W-1:0] != '0;
  endfunction

  // The highest lane word index must still be inside the memory; no wrap.
  function automatic logic out_of_range(input logic [PC_WIDTH-1:0] a);
    logic [PC_WIDTH:0] last;
    last = {3'b000, a[PC_WIDTH-1:2]} + (PC_WIDTH+1)'(LANES - 1);
    return last >= (PC_WIDTH+1)'(WORDS);
  endfunction

  // Word address of lane k; only used when the request is known in range.
  function automatic logic [ADD_WIDTH-1:0] lane_addr(input logic [PC_WIDTH-1:0] a,
                                                     input int k);
    return ADD_WIDTH'(a[PC_WIDTH-1:2]) + ADD_WIDTH'(k);
  endfunction

  logic [I_WIDTH-1:0]  ram [WORDS];

  state_t              state_q;
  logic                load_busy_q;
  logic                ready_q;

  logic [PC_WIDTH-1:0] pc_q    [2];
  logic [1:0]          fault_q [2];
  logic [RW-1:0]       instr_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;

  logic                vld_p0;
  logic [1:0]          fault_p0;
  logic                pop;

  // ---- stage p0: request acceptance and fault classification ----
  assign bus.req_ready = ready_q & ~bus.load_en & ~bus.flush;
  assign vld_p0        = bus.req_valid & bus.req_ready;
  assign fault_p0      = {out_of_range(bus.pc), misaligned(bus.pc)};
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  // Next buffer occupancy: flush empties it, otherwise push/pop bookkeeping.
  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      case ({vld_p0, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Loader writes, honoured only while the state machine owns LOAD.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && bus.we) begin
      ram[bus.waddr] <= bus.wdata;
    end
  end

  // ---- stage p1: synchronous read lands in the response buffer slot ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      pc_q[wr_ptr_q]    <= bus.pc;
      fault_q[wr_ptr_q] <= fault_p0;
      for (int k = 0; k < LANES; k++) begin
        instr_q[wr_ptr_q][k*I_WIDTH +: I_WIDTH] <=
          (fault_p0 != 2'b00) ? '0 : ram[lane_addr(bus.pc, k)];
      end
    end
  end

  // Response buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (vld_p0) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Ownership state machine with registered ready and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      load_busy_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (bus.load_en) begin
            if (count_q != 2'd0) begin
              state_q <= S_DRAIN;
            end else begin
              state_q     <= S_LOAD;
              load_busy_q <= 1'b1;
            end
          end else begin
            ready_q <= (count_d < 2'd2);
          end
        end
        S_DRAIN: begin
          if (!bus.load_en) begin
            state_q <= S_RUN;
            ready_q <= (count_d < 2'd2);
          end else if (count_q == 2'd0) begin
            state_q     <= S_LOAD;
            load_busy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!bus.load_en) begin
            state_q     <= S_RUN;
            load_busy_q <= 1'b0;
            ready_q     <= (count_d < 2'd2);
          end
        end
        default: begin
          state_q     <= S_RUN;
          load_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p2: buffer head drives the response port, zero when empty ----
  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_pc    = bus.rsp_valid ? pc_q[rd_ptr_q]    : '0;
  assign bus.rsp_fault = bus.rsp_valid ? fault_q[rd_ptr_q] : 2'b00;
  assign bus.rsp_instr = bus.rsp_valid ? instr_q[rd_ptr_q] : '0;
  assign bus.load_busy = load_busy_q;

endmodule
